// File: rtl/vga_pkg.sv
// Shared VGA timing constants, capture FSM state type and counter helpers
// for the VGA input/output blocks.
package vga_pkg;

  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned IMG_DIM  = 225;

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE
  } cap_state_e;

  // Saturating increment for the sync position counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Samples HS/VS on pixel-enable ticks, flags their falling edges and keeps
// the pixel position within the line (hcount) and the line within the frame (vline).
module vga_sync_tracker
  import vga_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_en,
  input  logic             i_hs,
  input  logic             i_vs,
  output logic             o_hs_fall,
  output logic             o_vs_fall,
  output logic [CNT_W-1:0] o_hcount,
  output logic [CNT_W-1:0] o_vline
);

  logic             r_hs_prev;
  logic             r_vs_prev;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vline;

  // Edges are qualified by the enable so downstream logic sees one-tick flags.
  assign o_hs_fall = i_pix_en & r_hs_prev & ~i_hs;
  assign o_vs_fall = i_pix_en & r_vs_prev & ~i_vs;
  assign o_hcount  = r_hcount;
  assign o_vline   = r_vline;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_hcount  <= '0;
      r_vline   <= '0;
    end else if (i_pix_en) begin
      r_hs_prev <= i_hs;
      r_vs_prev <= i_vs;
      r_hcount  <= o_hs_fall ? '0 : sat_inc(r_hcount);
      if (o_vs_fall)
        r_vline <= '0;
      else if (o_hs_fall)
        r_vline <= sat_inc(r_vline);
    end
  end

endmodule

// File: rtl/vga_frame_capture.sv
// Captures a WIN_W x WIN_H window of an incoming VGA stream into image RAM
// using the column-major layout addr = x*WIN_H + y.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int unsigned WIN_W   = IMG_DIM,
  parameter int unsigned WIN_H   = IMG_DIM,
  parameter int unsigned H_START = H_SYNC + H_BP,
  parameter int unsigned V_START = V_SYNC + V_BP,
  parameter int unsigned AW      = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PIX_EN,
  input  logic          HS_IN,
  input  logic          VS_IN,
  input  logic [7:0]    COLOUR_IN,
  input  logic          ARM,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [7:0]    WR_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          FRAME_ERR
);

  localparam logic [CNT_W-1:0] H_LO     = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_HI     = CNT_W'(H_START + WIN_W);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_START + WIN_W - 1);
  localparam logic [CNT_W-1:0] V_LO     = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI     = CNT_W'(V_START + WIN_H);
  localparam logic [AW-1:0]    ROW_STEP = AW'(WIN_H);
  localparam logic [AW-1:0]    LAST_ROW = AW'(WIN_H - 1);

  logic             w_hs_fall;
  logic             w_vs_fall;
  logic [CNT_W-1:0] w_hcount;
  logic [CNT_W-1:0] w_vline;
  logic             w_active;
  logic             w_last_col;
  logic [AW-1:0]    w_pix_addr;

  cap_state_e       r_state;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_row;
  logic             r_line_active;

  vga_sync_tracker u_sync (
    .i_clk     (CLK),
    .i_rst     (RESET),
    .i_pix_en  (PIX_EN),
    .i_hs      (HS_IN),
    .i_vs      (VS_IN),
    .o_hs_fall (w_hs_fall),
    .o_vs_fall (w_vs_fall),
    .o_hcount  (w_hcount),
    .o_vline   (w_vline)
  );

  // The HS edge tick itself is never a pixel: a line cut short by an early
  // HS loses the pixel at that tick along with the rest of the line.
  assign w_active   = PIX_EN && !w_hs_fall &&
                      (w_hcount >= H_LO) && (w_hcount < H_HI) &&
                      (w_vline  >= V_LO) && (w_vline  < V_HI);
  assign w_last_col = (w_hcount == H_LAST);
  assign w_pix_addr = r_line_active ? (r_addr + ROW_STEP) : r_row;

  assign BUSY = (r_state == WAIT_VS) || (r_state == CAPTURE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_row         <= '0;
      r_line_active <= 1'b0;
      WR_EN         <= 1'b0;
      WR_ADDR       <= '0;
      WR_DATA       <= '0;
      DONE          <= 1'b0;
      FRAME_ERR     <= 1'b0;
    end else begin
      WR_EN     <= 1'b0;
      DONE      <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ARM)
            r_state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (w_vs_fall) begin
            r_state       <= CAPTURE;
            r_addr        <= '0;
            r_row         <= '0;
            r_line_active <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_vs_fall) begin
            FRAME_ERR     <= 1'b1;
            r_line_active <= 1'b0;
            r_state       <= WAIT_VS;
          end else if (w_active) begin
            WR_EN   <= 1'b1;
            WR_ADDR <= w_pix_addr;
            WR_DATA <= COLOUR_IN;
            r_addr  <= w_pix_addr;
            if (w_last_col) begin
              r_row         <= r_row + 1'b1;
              r_line_active <= 1'b0;
              if (r_row == LAST_ROW) begin
                DONE    <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_line_active <= 1'b1;
            end
          end else if (w_hs_fall && r_line_active) begin
            // Short line: still consumes its row.
            r_row         <= r_row + 1'b1;
            r_line_active <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
